// File: rtl/alu_seq_4_bit_if.sv
// Bus bundle between the issue/writeback stage and its surroundings:
// instruction handshake, external ALU connection, result and debug ports.
interface alu_seq_4_bit_if #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 2
);
  logic              instr_valid;
  logic              instr_ready;
  logic              instr_ld;
  logic [2:0]        instr_op;
  logic [ADDR_W-1:0] instr_rd;
  logic [ADDR_W-1:0] instr_rs1;
  logic [ADDR_W-1:0] instr_rs2;
  logic [DATA_W-1:0] instr_imm;
  logic [2:0]        alu_op;
  logic [DATA_W-1:0] alu_in1;
  logic [DATA_W-1:0] alu_in2;
  logic [DATA_W-1:0] alu_out;
  logic              res_valid;
  logic [ADDR_W-1:0] res_rd;
  logic [DATA_W-1:0] res_data;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport slave (
    input  instr_valid, instr_ld, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
    input  alu_out, dbg_addr,
    output instr_ready, alu_op, alu_in1, alu_in2, res_valid, res_rd, res_data, dbg_data
  );

  modport master (
    output instr_valid, instr_ld, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
    output alu_out, dbg_addr,
    input  instr_ready, alu_op, alu_in1, alu_in2, res_valid, res_rd, res_data, dbg_data
  );
endinterface

// File: rtl/alu_seq_4_bit.sv
// Issue/writeback stage in front of an external combinational 4-bit ALU.
// One instruction in flight at a time: IDLE -> EXEC -> WB, or IDLE -> WB for loads.
module alu_seq_4_bit #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned REG_N  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input logic            clk,
  input logic            rst,
  alu_seq_4_bit_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

  state_e            state_q, state_d;
  logic [2:0]        alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_in1_q, alu_in1_d;
  logic [DATA_W-1:0] alu_in2_q, alu_in2_d;
  logic [ADDR_W-1:0] res_rd_q, res_rd_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [DATA_W-1:0] rf_q [REG_N];
  logic              rf_we;
  logic              ready;
  logic              res_valid;

  always_comb begin
    state_d    = state_q;
    alu_op_d   = alu_op_q;
    alu_in1_d  = alu_in1_q;
    alu_in2_d  = alu_in2_q;
    res_rd_d   = res_rd_q;
    res_data_d = res_data_q;
    rf_we      = 1'b0;
    ready      = 1'b0;
    res_valid  = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (bus.instr_valid) begin
          // Destination is latched at accept for both paths.
          res_rd_d = bus.instr_rd;
          if (bus.instr_ld) begin
            res_data_d = bus.instr_imm;
            state_d    = StWb;
          end else begin
            alu_op_d  = bus.instr_op;
            alu_in1_d = rf_q[bus.instr_rs1];
            alu_in2_d = rf_q[bus.instr_rs2];
            state_d   = StExec;
          end
        end
      end
      StExec: begin
        res_data_d = bus.alu_out;
        state_d    = StWb;
      end
      StWb: begin
        res_valid = 1'b1;
        rf_we     = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      alu_op_q   <= '0;
      alu_in1_q  <= '0;
      alu_in2_q  <= '0;
      res_rd_q   <= '0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      alu_op_q   <= alu_op_d;
      alu_in1_q  <= alu_in1_d;
      alu_in2_q  <= alu_in2_d;
      res_rd_q   <= res_rd_d;
      res_data_q <= res_data_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[res_rd_q] <= res_data_q;
    end
  end

  assign bus.instr_ready = ready;
  assign bus.alu_op      = alu_op_q;
  assign bus.alu_in1     = alu_in1_q;
  assign bus.alu_in2     = alu_in2_q;
  assign bus.res_valid   = res_valid;
  assign bus.res_rd      = res_rd_q;
  assign bus.res_data    = res_data_q;
  assign bus.dbg_data    = rf_q[bus.dbg_addr];
endmodule

// File: tb/tb_alu_seq_4_bit.sv
// Bench for alu_seq_4_bit: directed scenarios with literal results plus random
// instructions checked each cycle against a transaction-level model.
module tb_alu_seq_4_bit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seq_4_bit_if #(.DATA_W(4), .ADDR_W(2)) bus ();

  alu_seq_4_bit #(.DATA_W(4), .REG_N(4), .ADDR_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stand-in for the external ALU.
  function automatic logic [3:0] alu_f(input logic [2:0] op, input logic [3:0] a,
                                       input logic [3:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return ~b;
      3'd2:    return a - b;
      3'd3:    return a & b;
      3'd4:    return a | b;
      3'd5:    return a ^ b;
      3'd6:    return {3'b000, a == b};
      default: return {3'b000, a != b};
    endcase
  endfunction

  assign bus.alu_out = alu_f(bus.alu_op, bus.alu_in1, bus.alu_in2);

  logic       rand_dbg = 1'b0;
  logic [1:0] dbg_sel  = '0;
  logic [1:0] dbg_rand = '0;
  assign bus.dbg_addr = rand_dbg ? dbg_rand : dbg_sel;
  always @(posedge clk) begin
    #2 dbg_rand = 2'($urandom);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level model: at most one instruction outstanding, its result due
  // one cycle (load) or two cycles (ALU) after the accepting edge.
  int         cyc = 0;
  logic [3:0] m_rf [4];
  bit         m_busy;
  int         m_res_cyc;
  logic [1:0] m_rd;
  logic [3:0] m_val;
  logic [2:0] m_op;
  logic [3:0] m_in1, m_in2;
  bit         cmp_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) m_rf[i] = '0;
      m_busy = 1'b0;
      m_rd   = '0;
      m_val  = '0;
      m_op   = '0;
      m_in1  = '0;
      m_in2  = '0;
    end else if (m_busy && cyc == m_res_cyc) begin
      m_rf[m_rd] = m_val;
      m_busy     = 1'b0;
    end else if (!m_busy && bus.instr_valid) begin
      m_busy = 1'b1;
      m_rd   = bus.instr_rd;
      if (bus.instr_ld) begin
        m_val     = bus.instr_imm;
        m_res_cyc = cyc + 1;
      end else begin
        m_op      = bus.instr_op;
        m_in1     = m_rf[bus.instr_rs1];
        m_in2     = m_rf[bus.instr_rs2];
        m_val     = alu_f(m_op, m_in1, m_in2);
        m_res_cyc = cyc + 2;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && cmp_en) begin
      logic exp_v;
      exp_v = m_busy && (cyc == m_res_cyc);
      chk("instr_ready", bus.instr_ready, !m_busy);
      chk("res_valid", bus.res_valid, exp_v);
      if (exp_v) begin
        chk("res_rd", bus.res_rd, m_rd);
        chk("res_data", bus.res_data, m_val);
      end
      chk("alu_op", bus.alu_op, m_op);
      chk("alu_in1", bus.alu_in1, m_in1);
      chk("alu_in2", bus.alu_in2, m_in2);
      chk("dbg_data", bus.dbg_data, m_rf[bus.dbg_addr]);
    end
  end

  task automatic drive(input bit ld, input logic [2:0] op, input logic [1:0] rd,
                       input logic [1:0] rs1, input logic [1:0] rs2, input logic [3:0] imm);
    bus.instr_ld  = ld;
    bus.instr_op  = op;
    bus.instr_rd  = rd;
    bus.instr_rs1 = rs1;
    bus.instr_rs2 = rs2;
    bus.instr_imm = imm;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.instr_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("ready before issue", bus.instr_ready, 1);
  endtask

  // Issue one instruction (called at a negedge) and return the written value.
  task automatic run(input bit ld, input logic [2:0] op, input logic [1:0] rd,
                     input logic [1:0] rs1, input logic [1:0] rs2, input logic [3:0] imm,
                     output logic [3:0] d);
    bit got = 1'b0;
    wait_ready();
    drive(ld, op, rd, rs1, rs2, imm);
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    d = 'x;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (bus.res_valid) begin
        got = 1'b1;
        d   = bus.res_data;
      end
    end
    chk("result pulse seen", got, 1);
  endtask

  task automatic dbg_chk(input string name, input logic [1:0] addr, input logic [3:0] exp);
    dbg_sel = addr;
    @(negedge clk);
    chk(name, bus.dbg_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] d, d2;
    logic [5:0] pat;
    int         pulses;
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    drive(1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 4'd0);
    repeat (2) @(negedge clk);
    chk("reset alu_op", bus.alu_op, 0);
    chk("reset alu_in1", bus.alu_in1, 0);
    chk("reset alu_in2", bus.alu_in2, 0);
    chk("reset res_valid", bus.res_valid, 0);
    chk("reset res_rd", bus.res_rd, 0);
    chk("reset res_data", bus.res_data, 0);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1 chk("reset rf", bus.dbg_data, 0);
    end
    rst = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    chk("ready after reset", bus.instr_ready, 1);

    // Add with operands from two loaded registers.
    run(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 4'd5, d);
    chk("t1 load r0", d, 5);
    run(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 4'd3, d);
    run(1'b0, 3'd0, 2'd2, 2'd0, 2'd1, 4'd0, d);
    chk("t1 add result", d, 8);
    chk("t1 alu_in1", bus.alu_in1, 5);
    chk("t1 alu_in2", bus.alu_in2, 3);
    chk("t1 alu_op", bus.alu_op, 0);
    dbg_chk("t1 r2", 2'd2, 4'd8);

    // Add wraps at 4 bits; rs1 == rs2.
    run(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 4'd9, d);
    run(1'b0, 3'd0, 2'd3, 2'd0, 2'd0, 4'd0, d);
    chk("t2 wrap", d, 2);
    dbg_chk("t2 r3", 2'd3, 4'd2);

    // Compare writes r0, next op reads the new r0.
    run(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 4'd7, d);
    run(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 4'd7, d);
    run(1'b0, 3'd6, 2'd0, 2'd0, 2'd1, 4'd0, d);
    chk("t3 eq", d, 1);
    run(1'b0, 3'd7, 2'd2, 2'd0, 2'd1, 4'd0, d);
    chk("t3 neq new r0", d, 1);
    chk("t3 alu_in1 new r0", bus.alu_in1, 1);

    // Two back-to-back ops with valid held high. r0=1, r1=7.
    wait_ready();
    drive(1'b0, 3'd0, 2'd2, 2'd0, 2'd1, 4'd0);
    bus.instr_valid = 1'b1;
    pulses = 0;
    d  = 'x;
    d2 = 'x;
    for (int k = 0; k < 6; k++) begin
      pat[5-k] = bus.instr_ready;
      if (bus.res_valid) begin
        pulses++;
        if (pulses == 1) d = bus.res_data;
        else d2 = bus.res_data;
      end
      @(posedge clk);
      #1;
      if (k == 0) drive(1'b0, 3'd2, 2'd3, 2'd2, 2'd0, 4'd0);
      if (k == 3) bus.instr_valid = 1'b0;
      @(negedge clk);
    end
    if (bus.res_valid) pulses++;
    chk("t4 ready pattern", pat, 6'b100100);
    chk("t4 pulse count", pulses, 2);
    chk("t4 first result", d, 8);
    chk("t4 second result", d2, 7);

    // Bitwise not of rs2.
    run(1'b1, 3'd0, 2'd2, 2'd0, 2'd0, 4'd4, d);
    run(1'b0, 3'd1, 2'd1, 2'd0, 2'd2, 4'd0, d);
    chk("t5 not", d, 4'b1011);

    // Reset during EXEC discards the pending writeback.
    run(1'b1, 3'd0, 2'd3, 2'd0, 2'd0, 4'd6, d);
    dbg_chk("t6 r3 preloaded", 2'd3, 4'd6);
    wait_ready();
    drive(1'b0, 3'd0, 2'd3, 2'd0, 2'd0, 4'd0);
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.res_valid) pulses++;
    end
    chk("t6 no pulse", pulses, 0);
    chk("t6 ready", bus.instr_ready, 1);
    dbg_chk("t6 r3 cleared", 2'd3, 4'd0);

    // Random traffic against the model.
    rand_dbg = 1'b1;
    for (int n = 0; n < 200; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run(1'($urandom), 3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
          4'($urandom), d);
    end
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
